multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-003 SHALL have port opCode, input, 6 bits: IR[31:26] from the datapath.
REQ-004 SHALL have port mem_ready, input, 1 bit: memory access complete; tie high for single-cycle RAM.
REQ-005 SHALL have ports PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst: output, 1 bit each, datapath controls.
REQ-006 SHALL have port PCSource, output, 2 bits: 00 ALU result, 01 branch target, 10 jump target.
REQ-007 SHALL have port ALUSrcB, output, 3 bits: 000 B, 001 const 4, 010 sign-extend, 011 shifted sign-extend.
REQ-008 SHALL have port ALUOp, output, 2 bits: 00 add, 01 subtract, 10 funct field.
REQ-009 SHALL have port instr_done, output, 1 bit: one-cycle pulse in the final state of each instruction.
REQ-010 SHALL have port illegal_op, output, 1 bit: one-cycle pulse when DECODE sees an unsupported opcode.
REQ-011 SHALL have port state, output, 4 bits: current state encoding, for debug.

Function
REQ-012 SHALL use a Moore FSM. All outputs decode from the registered state only. Exception: mem_ready gates IRWrite and PCWrite in FETCH.
REQ-013 SHALL use state encodings FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11.
REQ-014 SHALL drive every output not listed for a state to 0. In any state, PCSource=00, ALUSrcB=000 and ALUOp=00 unless that state lists another value.
REQ-015 FETCH SHALL assert MemRead, ALUSrcB=001 and ALUOp=00. It SHALL assert IRWrite and PCWrite only when mem_ready=1. It SHALL stay in FETCH while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-016 DECODE SHALL drive ALUSrcB=011 and ALUOp=00 to compute the branch target. Next state by opCode:
- 100011 or 101011 → MEMADR
- 000000 → EXEC
- 000100 → BRANCH
- 000010 → JUMP
- 001000 → ADDI_EX
- any other opcode → FETCH, with illegal_op pulsed.
REQ-017 MEMADR SHALL drive ALUSrcA=1 and ALUSrcB=010. Next state is MEMRD for opCode 100011, otherwise MEMWR.
REQ-018 MEMRD SHALL drive MemRead and IorD. It SHALL hold while mem_ready=0, then go to MEMWB.
REQ-019 MEMWB SHALL drive RegWrite and MemtoReg with RegDst=0, pulse instr_done, and go to FETCH.
REQ-020 MEMWR SHALL drive MemWrite and IorD while it waits. On mem_ready=1 it SHALL pulse instr_done and go to FETCH.
REQ-021 EXEC SHALL drive ALUSrcA=1, ALUSrcB=000 and ALUOp=10, then go to RWB.
REQ-022 RWB SHALL drive RegWrite and RegDst=1, pulse instr_done, and go to FETCH.
REQ-023 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=000, ALUOp=01, PCWriteCond=1 and PCSource=01, pulse instr_done, and go to FETCH.
REQ-024 JUMP SHALL drive PCWrite and PCSource=10, pulse instr_done, and go to FETCH.
REQ-025 ADDI_EX SHALL drive ALUSrcA=1, ALUSrcB=010 and ALUOp=00, then go to ADDI_WB.
REQ-026 ADDI_WB SHALL drive RegWrite with RegDst=0 and MemtoReg=0, pulse instr_done, and go to FETCH.
REQ-027 Unused encodings 12-15 SHALL go to FETCH on the next edge with all outputs 0.
REQ-028 Latency in cycles, with mem_ready held high:
- lw: 5
- sw: 4
- R-type: 4
- addi: 4
- beq: 3
- j: 3
- illegal: 2

Reset
REQ-029 With reset=1 at a rising clk edge, state SHALL become FETCH on that edge, overriding any next-state decision, including mid-instruction and mid-wait.
REQ-030 While reset=1, all outputs SHALL be 0 (masked). After reset falls, FETCH outputs SHALL appear in the same cycle.

Configuration
REQ-031 Macro ADDI_SUPPORT_EN: when defined, ADDI_EX and ADDI_WB exist. When undefined, opcode 001000 SHALL be treated as illegal (illegal_op pulse, return to FETCH), and encodings 10-11 SHALL behave as unused.

Structure
REQ-032 A shared package SHALL hold the state enum, the opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI) and the ALUOp, ALUSrcB and PCSource encodings, for reuse by the datapath.
REQ-033 The design SHALL have one sub-module, control_output_decode: combinational, state in, control word out. The state register and next-state logic SHALL stay in multicycle_control.

Verification
REQ-034 Reset, then opCode=100011 with mem_ready=1 → state sequence 0,1,2,3,4,0; instr_done high only in state 4; RegWrite=1 and MemtoReg=1 in state 4.
REQ-035 opCode=101011 with mem_ready=0 for 3 cycles in MEMWR → state holds at 5 for 3 cycles with MemWrite=1 and IorD=1; exit on mem_ready=1.
REQ-036 opCode=000100 → states 0,1,8; in state 8: PCWriteCond=1, PCSource=01, ALUOp=01, PCWrite=0.
REQ-037 opCode=111111 → states 0,1,0; illegal_op=1 for exactly one cycle, in DECODE.
REQ-038 reset asserted during EXEC → next state 0 and all outputs 0 while reset=1. opCode=001000 is checked both with ADDI_SUPPORT_EN defined (states 0,1,10,11) and without it (illegal_op=1).

Source files
------------

// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_pkg
// Brief    : Shared state, opcode and control-field encodings for the
//            multicycle MIPS controller and its datapath.
// Revision : 1.0 - initial release
// ============================================================================
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [2:0] {
        SRCB_B        = 3'b000,
        SRCB_FOUR     = 3'b001,
        SRCB_SEXT     = 3'b010,
        SRCB_SEXT_SHL = 3'b011
    } alu_src_b_t;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_BRANCH = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pc_source_t;

    typedef struct packed {
        logic       pc_write_cond;
        logic       pc_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        pc_source_t pc_source;
        alu_src_b_t alu_src_b;
        alu_op_t    alu_op;
        logic       instr_done;
    } ctrl_word_t;

endpackage
`default_nettype wire

// File: rtl/multicycle_control_output_decode.sv
`default_nettype none
// ============================================================================
// Module   : control_output_decode
// Brief    : Pure state-to-control-word decode (Moore outputs). Build macro
//            ADDI_SUPPORT_EN enables the ADDI_EX / ADDI_WB words.
// Revision : 1.0 - initial release
// ============================================================================
module control_output_decode
    import multicycle_control_pkg::*;
(
    input  state_t     i_state,
    output ctrl_word_t o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.ir_write  = 1'b1;
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_DECODE: begin
                o_ctrl.alu_src_b = SRCB_SEXT_SHL;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_SEXT;
            end
            S_MEMRD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                o_ctrl.mem_write  = 1'b1;
                o_ctrl.i_or_d     = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            S_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_B;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_src_b     = SRCB_B;
                o_ctrl.alu_op        = ALUOP_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = PCSRC_BRANCH;
                o_ctrl.instr_done    = 1'b1;
            end
            S_JUMP: begin
                o_ctrl.pc_write   = 1'b1;
                o_ctrl.pc_source  = PCSRC_JUMP;
                o_ctrl.instr_done = 1'b1;
            end
`ifdef ADDI_SUPPORT_EN
            S_ADDI_EX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_SEXT;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_ADDI_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
`endif
            default: o_ctrl = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Brief    : Multicycle MIPS control FSM (state register + next-state logic).
//            Build macro ADDI_SUPPORT_EN adds the addi instruction path.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opCode,
    input  logic       mem_ready,
    output logic       PCWriteCond,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] PCSource,
    output logic [2:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t     r_state;
    state_t     w_next_state;
    logic       w_illegal;
    logic       w_gate;
    logic       w_run;
    ctrl_word_t w_ctrl;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = S_FETCH;
        w_illegal    = 1'b0;
        case (r_state)
            S_FETCH:  w_next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opCode)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = S_EXEC;
                    OP_BEQ:       w_next_state = S_BRANCH;
                    OP_J:         w_next_state = S_JUMP;
`ifdef ADDI_SUPPORT_EN
                    OP_ADDI:      w_next_state = S_ADDI_EX;
`else
                    OP_ADDI: begin
                        w_next_state = S_FETCH;
                        w_illegal    = 1'b1;
                    end
`endif
                    default: begin
                        w_next_state = S_FETCH;
                        w_illegal    = 1'b1;
                    end
                endcase
            end
            S_MEMADR: w_next_state = (opCode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next_state = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  w_next_state = S_FETCH;
            S_MEMWR:  w_next_state = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   w_next_state = S_RWB;
            S_RWB:    w_next_state = S_FETCH;
            S_BRANCH: w_next_state = S_FETCH;
            S_JUMP:   w_next_state = S_FETCH;
`ifdef ADDI_SUPPORT_EN
            S_ADDI_EX: w_next_state = S_ADDI_WB;
            S_ADDI_WB: w_next_state = S_FETCH;
`endif
            default:  w_next_state = S_FETCH;
        endcase
    end

    control_output_decode u_decode (
        .i_state (r_state),
        .o_ctrl  (w_ctrl)
    );

    // Memory handshake qualifies the fetch writes and the store completion pulse.
    assign w_gate = ((r_state == S_FETCH) || (r_state == S_MEMWR)) ? mem_ready : 1'b1;
    assign w_run  = ~reset;

    assign PCWriteCond = w_run & w_ctrl.pc_write_cond;
    assign PCWrite     = w_run & w_ctrl.pc_write & w_gate;
    assign IorD        = w_run & w_ctrl.i_or_d;
    assign MemRead     = w_run & w_ctrl.mem_read;
    assign MemWrite    = w_run & w_ctrl.mem_write;
    assign MemtoReg    = w_run & w_ctrl.mem_to_reg;
    assign IRWrite     = w_run & w_ctrl.ir_write & w_gate;
    assign ALUSrcA     = w_run & w_ctrl.alu_src_a;
    assign RegWrite    = w_run & w_ctrl.reg_write;
    assign RegDst      = w_run & w_ctrl.reg_dst;
    assign PCSource    = {2{w_run}} & w_ctrl.pc_source;
    assign ALUSrcB     = {3{w_run}} & w_ctrl.alu_src_b;
    assign ALUOp       = {2{w_run}} & w_ctrl.alu_op;
    assign instr_done  = w_run & w_ctrl.instr_done & w_gate;
    assign illegal_op  = w_run & w_illegal;
    assign state       = {4{w_run}} & r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Brief    : Directed self-checking bench for multicycle_control.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opCode;
    logic       mem_ready;
    logic       PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, ALUSrcA, RegWrite, RegDst, instr_done, illegal_op;
    logic [1:0] PCSource, ALUOp;
    logic [2:0] ALUSrcB;
    logic [3:0] state;
    logic [18:0] outs;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .reset(reset), .opCode(opCode), .mem_ready(mem_ready),
        .PCWriteCond(PCWriteCond), .PCWrite(PCWrite), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
        .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .instr_done(instr_done), .illegal_op(illegal_op),
        .state(state)
    );

    assign outs = {PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                   ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp, instr_done, illegal_op};

    // Field order: PCWC PCW IorD MRd MWr M2R IRW SrcA RegW RegDst | PCSrc SrcB ALUOp done ill
    localparam logic [18:0] E_FETCH_R = {10'b0101001000, 2'b00, 3'b001, 2'b00, 2'b00};
    localparam logic [18:0] E_FETCH_W = {10'b0001000000, 2'b00, 3'b001, 2'b00, 2'b00};
    localparam logic [18:0] E_DEC     = {10'b0000000000, 2'b00, 3'b011, 2'b00, 2'b00};
    localparam logic [18:0] E_DEC_ILL = {10'b0000000000, 2'b00, 3'b011, 2'b00, 2'b01};
    localparam logic [18:0] E_MEMADR  = {10'b0000000100, 2'b00, 3'b010, 2'b00, 2'b00};
    localparam logic [18:0] E_MEMRD   = {10'b0011000000, 2'b00, 3'b000, 2'b00, 2'b00};
    localparam logic [18:0] E_MEMWB   = {10'b0000010010, 2'b00, 3'b000, 2'b00, 2'b10};
    localparam logic [18:0] E_MEMWR_W = {10'b0010100000, 2'b00, 3'b000, 2'b00, 2'b00};
    localparam logic [18:0] E_MEMWR_D = {10'b0010100000, 2'b00, 3'b000, 2'b00, 2'b10};
    localparam logic [18:0] E_EXEC    = {10'b0000000100, 2'b00, 3'b000, 2'b10, 2'b00};
    localparam logic [18:0] E_RWB     = {10'b0000000011, 2'b00, 3'b000, 2'b00, 2'b10};
    localparam logic [18:0] E_BRANCH  = {10'b1000000100, 2'b01, 3'b000, 2'b01, 2'b10};
    localparam logic [18:0] E_JUMP    = {10'b0100000000, 2'b10, 3'b000, 2'b00, 2'b10};
    localparam logic [18:0] E_ADDI_EX = {10'b0000000100, 2'b00, 3'b010, 2'b00, 2'b00};
    localparam logic [18:0] E_ADDI_WB = {10'b0000000010, 2'b00, 3'b000, 2'b00, 2'b10};

    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b1; opCode = 6'd0;
        @(negedge clk); @(negedge clk); #1;
        n_checks++;
        if (outs !== 19'd0) $display("FAIL reset_outs got %b want %b", outs, 19'd0);
        else n_pass++;
        n_checks++;
        if (state !== 4'd0) $display("FAIL reset_state got %0d want 0", state);
        else n_pass++;
        reset = 1'b0; mem_ready = 1'b0; #1;
        n_checks++;
        if (outs !== E_FETCH_W) $display("FAIL fetch_wait_outs got %b want %b", outs, E_FETCH_W);
        else n_pass++;
        mem_ready = 1'b1; #1;
        n_checks++;
        if (outs !== E_FETCH_R) $display("FAIL fetch_ready_outs got %b want %b", outs, E_FETCH_R);
        else n_pass++;
        mem_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lw();
        logic [3:0]  es [0:4];
        logic [18:0] eo [0:4];
        es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        eo = '{E_FETCH_R, E_DEC, E_MEMADR, E_MEMRD, E_MEMWB};
        opCode = 6'b100011;
        for (int i = 0; i < 5; i++) begin
            mem_ready = 1'b1; #1;
            n_checks++;
            if (state !== es[i]) $display("FAIL lw_state[%0d] got %0d want %0d", i, state, es[i]);
            else n_pass++;
            n_checks++;
            if (outs !== eo[i]) $display("FAIL lw_outs[%0d] got %b want %b", i, outs, eo[i]);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_lw_wait();
        logic [3:0]  es [0:5];
        logic [18:0] eo [0:5];
        logic        mr [0:5];
        es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd4};
        eo = '{E_FETCH_R, E_DEC, E_MEMADR, E_MEMRD, E_MEMRD, E_MEMWB};
        mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        opCode = 6'b100011;
        for (int i = 0; i < 6; i++) begin
            mem_ready = mr[i]; #1;
            n_checks++;
            if (state !== es[i]) $display("FAIL lwwait_state[%0d] got %0d want %0d", i, state, es[i]);
            else n_pass++;
            n_checks++;
            if (outs !== eo[i]) $display("FAIL lwwait_outs[%0d] got %b want %b", i, outs, eo[i]);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_sw_wait();
        logic [3:0]  es [0:6];
        logic [18:0] eo [0:6];
        logic        mr [0:6];
        es = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5};
        eo = '{E_FETCH_R, E_DEC, E_MEMADR, E_MEMWR_W, E_MEMWR_W, E_MEMWR_W, E_MEMWR_D};
        mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        opCode = 6'b101011;
        for (int i = 0; i < 7; i++) begin
            mem_ready = mr[i]; #1;
            n_checks++;
            if (state !== es[i]) $display("FAIL sw_state[%0d] got %0d want %0d", i, state, es[i]);
            else n_pass++;
            n_checks++;
            if (outs !== eo[i]) $display("FAIL sw_outs[%0d] got %b want %b", i, outs, eo[i]);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_rtype();
        logic [3:0]  es [0:3];
        logic [18:0] eo [0:3];
        es = '{4'd0, 4'd1, 4'd6, 4'd7};
        eo = '{E_FETCH_R, E_DEC, E_EXEC, E_RWB};
        opCode = 6'b000000;
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1; #1;
            n_checks++;
            if (state !== es[i]) $display("FAIL rtype_state[%0d] got %0d want %0d", i, state, es[i]);
            else n_pass++;
            n_checks++;
            if (outs !== eo[i]) $display("FAIL rtype_outs[%0d] got %b want %b", i, outs, eo[i]);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_illegal();
        logic [3:0]  es [0:2];
        logic [18:0] eo [0:2];
        logic        mr [0:2];
        es = '{4'd0, 4'd1, 4'd0};
        eo = '{E_FETCH_R, E_DEC_ILL, E_FETCH_W};
        mr = '{1'b1, 1'b1, 1'b0};
        opCode = 6'b111111;
        for (int i = 0; i < 3; i++) begin
            mem_ready = mr[i]; #1;
            n_checks++;
            if (state !== es[i]) $display("FAIL illegal_state[%0d] got %0d want %0d", i, state, es[i]);
            else n_pass++;
            n_checks++;
            if (outs !== eo[i]) $display("FAIL illegal_outs[%0d] got %b want %b", i, outs, eo[i]);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_addi();
`ifdef ADDI_SUPPORT_EN
        logic [3:0]  es [0:3];
        logic [18:0] eo [0:3];
        es = '{4'd0, 4'd1, 4'd10, 4'd11};
        eo = '{E_FETCH_R, E_DEC, E_ADDI_EX, E_ADDI_WB};
        opCode = 6'b001000;
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1; #1;
            n_checks++;
            if (state !== es[i]) $display("FAIL addi_state[%0d] got %0d want %0d", i, state, es[i]);
            else n_pass++;
            n_checks++;
            if (outs !== eo[i]) $display("FAIL addi_outs[%0d] got %b want %b", i, outs, eo[i]);
            else n_pass++;
            @(negedge clk);
        end
`else
        logic [3:0]  es [0:2];
        logic [18:0] eo [0:2];
        logic        mr [0:2];
        es = '{4'd0, 4'd1, 4'd0};
        eo = '{E_FETCH_R, E_DEC_ILL, E_FETCH_W};
        mr = '{1'b1, 1'b1, 1'b0};
        opCode = 6'b001000;
        for (int i = 0; i < 3; i++) begin
            mem_ready = mr[i]; #1;
            n_checks++;
            if (state !== es[i]) $display("FAIL addi_ill_state[%0d] got %0d want %0d", i, state, es[i]);
            else n_pass++;
            n_checks++;
            if (outs !== eo[i]) $display("FAIL addi_ill_outs[%0d] got %b want %b", i, outs, eo[i]);
            else n_pass++;
            @(negedge clk);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [3:0]  es [0:6];
        logic [18:0] eo [0:6];
        logic [5:0]  op [0:6];
        logic        mr [0:6];
        es = '{4'd0, 4'd1, 4'd9, 4'd0, 4'd1, 4'd8, 4'd0};
        eo = '{E_FETCH_R, E_DEC, E_JUMP, E_FETCH_R, E_DEC, E_BRANCH, E_FETCH_W};
        op = '{6'b000010, 6'b000010, 6'b000010, 6'b000100, 6'b000100, 6'b000100, 6'b000100};
        mr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            opCode = op[i]; mem_ready = mr[i]; #1;
            n_checks++;
            if (state !== es[i]) $display("FAIL b2b_state[%0d] got %0d want %0d", i, state, es[i]);
            else n_pass++;
            n_checks++;
            if (outs !== eo[i]) $display("FAIL b2b_outs[%0d] got %b want %b", i, outs, eo[i]);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        // Reset during EXEC
        opCode = 6'b000000; mem_ready = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        n_checks++;
        if (state !== 4'd6) $display("FAIL rstmid_pre_state got %0d want 6", state);
        else n_pass++;
        reset = 1'b1; #1;
        n_checks++;
        if (outs !== 19'd0) $display("FAIL rstmid_mask got %b want %b", outs, 19'd0);
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if (outs !== 19'd0) $display("FAIL rstmid_hold got %b want %b", outs, 19'd0);
        else n_pass++;
        reset = 1'b0; mem_ready = 1'b0; #1;
        n_checks++;
        if (state !== 4'd0) $display("FAIL rstmid_state got %0d want 0", state);
        else n_pass++;
        n_checks++;
        if (outs !== E_FETCH_W) $display("FAIL rstmid_outs got %b want %b", outs, E_FETCH_W);
        else n_pass++;
        // Reset while a store waits on memory
        @(negedge clk);
        opCode = 6'b101011; mem_ready = 1'b1;
        @(negedge clk); @(negedge clk); @(negedge clk);
        mem_ready = 1'b0; #1;
        n_checks++;
        if (state !== 4'd5) $display("FAIL rstwait_pre_state got %0d want 5", state);
        else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; #1;
        n_checks++;
        if (state !== 4'd0) $display("FAIL rstwait_state got %0d want 0", state);
        else n_pass++;
        n_checks++;
        if (outs !== E_FETCH_W) $display("FAIL rstwait_outs got %b want %b", outs, E_FETCH_W);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lw_wait();
        test_sw_wait();
        test_rtype();
        test_illegal();
        test_addi();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
